// File: rtl/pingpong_read_stream.sv
// Reads full ping-pong RAM banks in strict 0,1,0,1 order, streams the words out
// through a 2-entry skid FIFO and hands each drained bank back to the writer.
module pingpong_read_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              bank0_full,
  input  logic              bank1_full,
  output logic              ram1_read_en,
  output logic [ADDR_W-1:0] ram1_read_address,
  input  logic [DATA_W-1:0] ram1_read,
  output logic              ram2_read_en,
  output logic [ADDR_W-1:0] ram2_read_address,
  input  logic [DATA_W-1:0] ram2_read,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bank0_release,
  output logic              bank1_release,
  output logic              overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  state_e            r_state;
  logic              r_exp_bank;
  logic              r_pend0;
  logic              r_pend1;
  logic              r_inflight;
  logic              r_overrun;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_fifo [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_last;
  logic              w_release;
  logic              w_rel0;
  logic              w_rel1;
  logic              w_exp_pend;
  logic [DATA_W-1:0] w_rd_data;

  assign out_valid  = (r_count != 2'd0);
  assign out_data   = r_fifo[r_rd_ptr];
  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_inflight;

  // Occupancy the FIFO will have once everything already requested has landed.
  assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == StRead) && (w_occ < 3'd2);
  assign w_last     = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_release  = (r_state == StDrain) && !r_inflight;
  assign w_rel0     = w_release & ~r_exp_bank;
  assign w_rel1     = w_release & r_exp_bank;
  assign w_exp_pend = r_exp_bank ? r_pend1 : r_pend0;
  assign w_rd_data  = r_exp_bank ? ram2_read : ram1_read;

  assign ram1_read_en      = w_issue & ~r_exp_bank;
  assign ram2_read_en      = w_issue & r_exp_bank;
  assign ram1_read_address = ((r_state == StRead) && !r_exp_bank) ? r_addr : '0;
  assign ram2_read_address = ((r_state == StRead) && r_exp_bank) ? r_addr : '0;
  assign bank0_release     = w_rel0;
  assign bank1_release     = w_rel1;
  assign overrun           = r_overrun;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_exp_bank <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_exp_pend) begin
            r_addr  <= '0;
            r_state <= StRead;
          end
        end
        StRead: begin
          if (w_issue) begin
            if (w_last) begin
              r_state <= StDrain;
            end else begin
              r_addr <= r_addr + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          if (!r_inflight) begin
            r_exp_bank <= ~r_exp_bank;
            r_state    <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A full pulse landing on the release cycle re-arms the bank without error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pend0 <= (r_pend0 & ~w_rel0) | bank0_full;
      r_pend1 <= (r_pend1 & ~w_rel1) | bank1_full;
      if ((bank0_full & r_pend0 & ~w_rel0) || (bank1_full & r_pend1 & ~w_rel1)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_rd_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/pingpong_read_stream.md
Name: pingpong_read_stream

Overview:
- Downstream consumer of the ping-pong double-buffer RAM pair.
- Waits for the writer side to flag a bank as full, then reads that bank's DEPTH words in order, alternating banks (bank0 = RAM1, bank1 = RAM2).
- Presents the words as a valid/ready byte stream to the note-playback stage and hands the drained bank back to the writer.
- Absorbs the 1-cycle RAM read latency and output backpressure with a 2-entry skid FIFO.

Parameters:
- DATA_W, 8, RAM word / stream width
- ADDR_W, 5, RAM address width
- DEPTH, 32, words per bank; must be ≤ 2^ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- bank0_full  in  1  1-cycle pulse: RAM1 holds a complete buffer
- bank1_full  in  1  1-cycle pulse: RAM2 holds a complete buffer
- ram1_read_en  out  1  RAM1 read strobe
- ram1_read_address  out  ADDR_W  RAM1 read address
- ram1_read  in  DATA_W  RAM1 read data, valid the cycle after ram1_read_en
- ram2_read_en  out  1  RAM2 read strobe
- ram2_read_address  out  ADDR_W  RAM2 read address
- ram2_read  in  DATA_W  RAM2 read data, valid the cycle after ram2_read_en
- out_data  out  DATA_W  stream data (FIFO head)
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready; transfer when out_valid & out_ready
- bank0_release  out  1  1-cycle pulse: RAM1 fully read, writer may refill
- bank1_release  out  1  1-cycle pulse: RAM2 fully read, writer may refill
- overrun  out  1  sticky error flag, cleared only by reset

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset (async assert) clears all flops. All outputs are 0 during and after reset. Expected bank = bank0; pending flags, FIFO, in-flight flag and address all cleared.
- Reset mid-operation abandons the current bank silently: no release pulse, and FIFO contents are discarded.
- pend0 and pend1 are registered flags.
  - bankN_full sets pendN.
  - A release of bank N clears pendN.
  - If bankN_full and bankN_release occur in the same cycle, pendN ends set and overrun is not raised.
  - If bankN_full arrives while pendN=1 or bank N is being read, overrun is set and the pulse is otherwise ignored.
  - bank0_full and bank1_full together are legal; both flags are set.
- FSM states:
  - IDLE: if pend of the expected bank = 1, load addr=0 and go to READ. The other bank's pend never starts a read; order is strictly 0,1,0,1...
  - READ: ramX_read_en = issue and ramX_read_address = addr, for the expected bank only. The other bank's read_en stays 0 and its address is 0.
    - issue = (fifo_count + inflight − pop) < 2, where pop = out_valid & out_ready.
    - On issue: addr increments. When the issued address is DEPTH−1, go to DRAIN.
  - DRAIN: once inflight=0, pulse the expected bank's release for exactly 1 cycle, toggle the expected bank, and go to IDLE.
- inflight is a registered copy of the previous cycle's issue.
  - When inflight=1, the selected bank's read data is pushed into the FIFO at that edge.
  - Push and pop in the same cycle are allowed; fifo_count stays in the range 0..2.
- Output: out_valid = (fifo_count ≠ 0). out_data = FIFO head, held stable while out_valid & ~out_ready.
- Latency:
  - bankN_full pulse in cycle 0 → pend set at cycle 1 → READ at cycle 2 (address 0 issued) → data pushed at the end of cycle 3 → out_valid=1 in cycle 4.
  - With out_ready held at 1, words stream one per cycle: cycles 4..(3+DEPTH).
- Release timing with out_ready=1: last issue in cycle DEPTH+1, release pulse in cycle DEPTH+3 (cycle 35 for DEPTH=32).
- FIFO may still hold data when release pulses; the next bank's reads may begin while old data drains.
- Addresses never exceed DEPTH−1; wrap to 0 only on the next bank start.

Test Plan:
- Reset, then bank0_full pulse in cycle 0 with RAM1[i]=i and out_ready=1 → out_valid first high in cycle 4 with data 0x00. Values 0x00..0x1F appear on consecutive cycles. bank0_release pulses in cycle 35 only; ram2_read_en never asserts.
- Both full pulses in the same cycle, RAM2[i]=0x80+i → stream 0x00..0x1F, then 0x80..0x9F. bank0_release precedes bank1_release. overrun=0.
- out_ready driven with pattern 1,0,0,1 repeating during a bank read → no word lost or duplicated, out_data stable while stalled, fifo_count never exceeds 2, read_en deasserts while the FIFO is full.
- bank0_full pulsed again while bank0 is being read → overrun=1 and stays 1. Sequence continues unaffected and no extra bank0 read occurs.
- bank1_full alone after reset → no read activity (expected bank is 0). A later bank0_full → bank0 read, then bank1 read.
- resetn asserted at word 10 of a bank read → all outputs 0 immediately (async) with no release pulse. A subsequent bank0_full restarts the read at address 0.
